fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
- Instruction-fetch stage wrapped around Program_counter.
- Consumes the registered PC and produces PC_Next for it, so it is both the stage after the PC register and the one before it.
- Issues in-order requests to an instruction memory with variable latency, using a req/gnt and rvalid handshake.
- Buffers returned words with their PC and hands them to decode over a valid/ready handshake. Redirects flush all in-flight fetches.

Parameters:
- XLEN, 32, address and instruction width.
- DEPTH, 2, instruction buffer entries; also the credit limit for outstanding plus buffered fetches.
- MAX_OUT, 2, maximum outstanding memory requests; must be <= DEPTH.

Ports:
- CLK  in  1  rising-edge clock.
- Reset_n  in  1  reset.
- PC  in  XLEN  current PC from Program_counter.
- PC_Next  out  XLEN  next PC to Program_counter.
- Imem_Req  out  1  fetch request valid.
- Imem_Addr  out  XLEN  fetch address; equals PC.
- Imem_Gnt  in  1  request accepted this cycle.
- Imem_Rvalid  in  1  response valid; responses return in request order.
- Imem_Rdata  in  XLEN  response instruction.
- Redirect  in  1  flush and restart at Redirect_Target.
- Redirect_Target  in  XLEN  new PC; bits [1:0] are ignored and treated as 0.
- Instr_Valid  out  1  buffer head valid.
- Instr  out  XLEN  head instruction.
- Instr_PC  out  XLEN  PC of the head instruction.
- Instr_Ready  in  1  decode accepts the head.

Behaviour:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- Reset state: Reset_n low clears, immediately and without a clock edge:
  - outstanding count, discard count, tag FIFO and instruction buffer;
  - Instr_Valid=0, Instr=0, Instr_PC=0, Imem_Req=0, PC_Next=PC.
- Issue condition: Imem_Req = Reset_n & !Redirect & (outstanding < MAX_OUT) & (outstanding + occupancy < DEPTH). This is combinational.
- Accept: accept = Imem_Req & Imem_Gnt. On accept, PC is pushed into the tag FIFO (depth MAX_OUT) and outstanding increments.
- PC_Next priority:
  - Redirect: {Redirect_Target[XLEN-1:2],2'b00};
  - else accept: PC+4, with wrap-around modulo 2^XLEN (0xFFFFFFFC -> 0);
  - else PC (stall).
- Response: Imem_Rvalid pops the tag FIFO and decrements outstanding.
  - Accept and Rvalid in the same cycle leave outstanding unchanged.
  - A response is pushed into the buffer as {tag PC, Rdata} only if discard==0 and !Redirect. Otherwise it is dropped.
  - If discard>0, a dropped response decrements discard.
- Redirect:
  - Next cycle the buffer is empty and Instr_Valid=0.
  - discard := outstanding - (Imem_Rvalid ? 1 : 0). Remaining tag entries stay in place and are popped by the discarded responses.
  - A pop and a redirect in the same cycle: the flush wins.
  - New requests may issue from the cycle after Redirect, even while discard>0. The in-order return guarantees the old responses arrive first.
- Output handshake: pop on Instr_Valid & Instr_Ready. Instr and Instr_PC are stable while Instr_Valid=1 and Instr_Ready=0.
- Full buffer: the credit rule guarantees space for every non-discarded response. A push and a pop in the same cycle are legal at any occupancy.
- Latency: a zero-wait memory (Gnt=1, Rvalid one cycle after accept) gives Instr_Valid two cycles after the PC is presented. Sustained throughput is one instruction per cycle when Instr_Ready=1 and DEPTH>=2.
- Protocol error: Imem_Rvalid while outstanding==0 is ignored. This is flagged by a simulation-only assertion.
- Integration: Program_counter uses an active-high synchronous Reset. The top level drives it with ~Reset_n.

Decomposition:
- Shared package fetch_pkg holds:
  - XLEN;
  - PC_INCR=4;
  - the fetch entry struct {pc, instr};
  - a clog2 helper for the counter widths.
- One natural sub-module, sync_fifo, parameterised in width and depth with push/pop/full/empty and a flush input. It is instantiated twice: tag FIFO (width XLEN) and instruction buffer (width 2*XLEN).

Test Plan:
- Reset release, PC=0, Gnt=1, Rvalid one cycle after each accept, Ready=1 -> Instr_PC 0x0,0x4,0x8,... on consecutive cycles; first Instr_Valid two cycles after reset release.
- Ready held 0 -> two words are buffered, then Imem_Req=0 and PC_Next==PC. Ready=1 -> the buffered words drain in order with no loss.
- Gnt=0 for 3 cycles at PC=0x20 -> PC_Next stays 0x20 and no tag is pushed. Gnt=1 -> PC_Next=0x24.
- Two requests outstanding (0x8, 0xC), Redirect to 0x103 -> PC_Next=0x100, both responses dropped; next Instr_PC=0x100 with the matching Rdata.
- Redirect in the same cycle as Rvalid, with one request outstanding -> response dropped, discard=0, next fetch from the target is delivered.
- Reset_n pulsed low between clock edges with Instr_Valid=1 -> Instr_Valid and Imem_Req go to 0 immediately; after release, fetch restarts with empty counters.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   XLEN          : address / instruction width
//   PC_INCR       : byte step between sequential fetch addresses
//   fetch_entry_t : layout of one instruction-buffer word, {pc, instr}
//   clog2_min1    : ceil(log2(value)), never less than 1, for counter widths
package fetch_pkg;

  localparam int XLEN    = 32;
  localparam int PC_INCR = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic int clog2_min1(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >>> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous flush.
//   clk, rst_n    : clock, asynchronous active-low reset (clears storage)
//   push, wdata   : write request and data; accepted when not full, or when
//                   full but a pop happens in the same cycle
//   pop, rdata    : read request and head data (rdata is the head entry)
//   flush         : empties the FIFO; wins over push and pop
//   full, empty   : status flags
//   count         : number of stored entries
module sync_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic [WIDTH-1:0]                 wdata,
  input  logic                             pop,
  input  logic                             flush,
  output logic [WIDTH-1:0]                 rdata,
  output logic                             full,
  output logic                             empty,
  output logic [clog2_min1(DEPTH+1)-1:0]   count
);

  localparam int PW = clog2_min1(DEPTH);
  localparam int CW = clog2_min1(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction-fetch stage sitting around the program-counter register: it
// reads the registered PC, issues in-order fetches to a variable-latency
// instruction memory, buffers the returned words with their PC, hands them
// to decode, and computes the PC for the next cycle.
//   CLK, Reset_n                      : clock, asynchronous active-low reset
//   PC / PC_Next                      : current PC in, next PC out
//   Imem_Req/Addr/Gnt                 : request handshake (Addr == PC)
//   Imem_Rvalid/Rdata                 : in-order responses
//   Redirect/Redirect_Target          : flush and restart at target (word aligned)
//   Instr_Valid/Instr/Instr_PC/Ready  : decode handshake
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int XLEN    = fetch_pkg::XLEN,
  parameter int DEPTH   = 2,
  parameter int MAX_OUT = 2
) (
  input  logic            CLK,
  input  logic            Reset_n,
  input  logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_Next,
  output logic            Imem_Req,
  output logic [XLEN-1:0] Imem_Addr,
  input  logic            Imem_Gnt,
  input  logic            Imem_Rvalid,
  input  logic [XLEN-1:0] Imem_Rdata,
  input  logic            Redirect,
  input  logic [XLEN-1:0] Redirect_Target,
  output logic            Instr_Valid,
  output logic [XLEN-1:0] Instr,
  output logic [XLEN-1:0] Instr_PC,
  input  logic            Instr_Ready
);

  localparam int OW = clog2_min1(MAX_OUT + 1);
  localparam int CW = clog2_min1(DEPTH + 1);
  localparam int SW = clog2_min1(DEPTH + MAX_OUT + 1);

  // The tag FIFO holds exactly one PC per outstanding request, so its count
  // is the outstanding count and its full flag is "outstanding == MAX_OUT".
  logic [OW-1:0]       tag_count;
  logic                tag_full, tag_empty;
  logic [XLEN-1:0]     tag_pc;
  logic [OW-1:0]       discard_q, discard_d;
  logic                accept, rsp_valid;
  logic                buf_push, buf_pop, buf_full, buf_empty;
  logic [CW-1:0]       buf_count;
  logic [2*XLEN-1:0]   buf_wdata, buf_rdata;
  logic [SW-1:0]       credit_used;

  assign Imem_Addr = PC;
  assign accept    = Imem_Req & Imem_Gnt;
  // Responses with nothing outstanding are ignored.
  assign rsp_valid = Imem_Rvalid & ~tag_empty;
  assign buf_pop   = ~buf_empty & Instr_Ready;
  assign buf_push  = rsp_valid & (discard_q == '0) & ~Redirect;
  assign buf_wdata = {tag_pc, Imem_Rdata};

  // Credit counts the entry being popped this cycle as already free; without
  // that, DEPTH=2 could only sustain one instruction every other cycle.
  assign credit_used = SW'(tag_count) + SW'(buf_count) - SW'(buf_pop);

  always_comb begin
    Imem_Req = Reset_n & ~Redirect & ~tag_full & (credit_used < SW'(DEPTH));
  end

  always_comb begin
    PC_Next = PC;
    if (Reset_n) begin
      if (Redirect) begin
        PC_Next = Redirect_Target & ~XLEN'(3);
      end else if (accept) begin
        PC_Next = PC + XLEN'(PC_INCR);
      end
    end
  end

  // On redirect every request still in flight, except one returning this
  // cycle, belongs to the old path; their tags are popped as they drain.
  always_comb begin
    discard_d = discard_q;
    if (Redirect) begin
      discard_d = tag_count - OW'(rsp_valid);
    end else if (rsp_valid && (discard_q != '0)) begin
      discard_d = discard_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      discard_q <= '0;
    end else begin
      discard_q <= discard_d;
    end
  end

  always_comb begin
    Instr_Valid = ~buf_empty;
    Instr       = '0;
    Instr_PC    = '0;
    if (!buf_empty) begin
      Instr_PC = buf_rdata[2*XLEN-1:XLEN];
      Instr    = buf_rdata[XLEN-1:0];
    end
  end

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk   (CLK),
    .rst_n (Reset_n),
    .push  (accept),
    .wdata (PC),
    .pop   (rsp_valid),
    .flush (1'b0),
    .rdata (tag_pc),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  sync_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_instr_buf (
    .clk   (CLK),
    .rst_n (Reset_n),
    .push  (buf_push),
    .wdata (buf_wdata),
    .pop   (buf_pop),
    .flush (Redirect),
    .rdata (buf_rdata),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

`ifndef SYNTHESIS
  rvalid_without_request : assert property (
    @(posedge CLK) disable iff (!Reset_n) !(Imem_Rvalid && tag_empty));

  instr_buffer_overflow : assert property (
    @(posedge CLK) disable iff (!Reset_n) !(buf_push && buf_full && !buf_pop));
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: models the PC register and an in-order
// instruction memory whose responses can be held back.
module tb_fetch_buffer;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic [31:0] PC;
  logic [31:0] PC_Next;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Gnt;
  logic        Imem_Rvalid;
  logic [31:0] Imem_Rdata;
  logic        Redirect;
  logic [31:0] Redirect_Target;
  logic        Instr_Valid;
  logic [31:0] Instr;
  logic [31:0] Instr_PC;
  logic        Instr_Ready;

  logic        mem_hold;
  logic [31:0] pend [$];
  int          checks = 0;
  int          errors = 0;

  fetch_buffer dut (
    .CLK             (CLK),
    .Reset_n         (Reset_n),
    .PC              (PC),
    .PC_Next         (PC_Next),
    .Imem_Req        (Imem_Req),
    .Imem_Addr       (Imem_Addr),
    .Imem_Gnt        (Imem_Gnt),
    .Imem_Rvalid     (Imem_Rvalid),
    .Imem_Rdata      (Imem_Rdata),
    .Redirect        (Redirect),
    .Redirect_Target (Redirect_Target),
    .Instr_Valid     (Instr_Valid),
    .Instr           (Instr),
    .Instr_PC        (Instr_PC),
    .Instr_Ready     (Instr_Ready)
  );

  always #5 CLK = ~CLK;

  // Program counter register with synchronous active-high reset (~Reset_n).
  always @(posedge CLK) begin
    if (!Reset_n) PC <= 32'h0;
    else          PC <= PC_Next;
  end

  // Memory: instruction word = 0x1000_0000 + address; one response per cycle,
  // earliest the cycle after accept, none while mem_hold is set.
  always @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      pend.delete();
      Imem_Rvalid <= 1'b0;
      Imem_Rdata  <= 32'h0;
    end else begin
      if (Imem_Req && Imem_Gnt) pend.push_back(Imem_Addr);
      if (!mem_hold && pend.size() > 0) begin
        Imem_Rvalid <= 1'b1;
        Imem_Rdata  <= 32'h1000_0000 + pend.pop_front();
      end else begin
        Imem_Rvalid <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    Reset_n = 1'b0; Redirect = 1'b0; Redirect_Target = 32'h0;
    Imem_Gnt = 1'b0; Instr_Ready = 1'b0; mem_hold = 1'b0;
    step(); step();
    chk("rst_valid",   {31'h0, Instr_Valid}, 32'h0);
    chk("rst_instr",   Instr,                32'h0);
    chk("rst_instrpc", Instr_PC,             32'h0);
    chk("rst_req",     {31'h0, Imem_Req},    32'h0);
    chk("rst_pcnext",  PC_Next,              32'h0);

    // Release reset between edges, zero-wait memory, decode always ready.
    Imem_Gnt = 1'b1; Instr_Ready = 1'b1; Reset_n = 1'b1; #1;
    chk("c0_req",    {31'h0, Imem_Req},    32'h1);
    chk("c0_pcnext", PC_Next,              32'h4);
    chk("c0_addr",   Imem_Addr,            32'h0);
    chk("c0_valid",  {31'h0, Instr_Valid}, 32'h0);
    step();
    chk("c1_valid",  {31'h0, Instr_Valid}, 32'h0);
    chk("c1_pcnext", PC_Next,              32'h8);
    for (int n = 2; n <= 6; n++) begin
      step();
      chk("stream_valid", {31'h0, Instr_Valid}, 32'h1);
      chk("stream_pc",    Instr_PC, 32'(4 * (n - 2)));
      chk("stream_instr", Instr,    32'h1000_0000 + 32'(4 * (n - 2)));
    end

    // Decode stalls: two words buffered, then no more requests.
    step(); Instr_Ready = 1'b0; #1;
    chk("stall7_req",    {31'h0, Imem_Req}, 32'h0);
    chk("stall7_pcnext", PC_Next,  32'h1C);
    chk("stall7_pc",     Instr_PC, 32'h14);
    step();
    chk("stall8_req",    {31'h0, Imem_Req}, 32'h0);
    chk("stall8_pcnext", PC_Next,  32'h1C);
    chk("stall8_pc",     Instr_PC, 32'h14);
    step();
    chk("stall9_pc",     Instr_PC, 32'h14);
    chk("stall9_instr",  Instr,    32'h1000_0014);
    step(); Instr_Ready = 1'b1; #1;
    chk("drain10_pc",     Instr_PC, 32'h14);
    chk("drain10_req",    {31'h0, Imem_Req}, 32'h1);
    chk("drain10_pcnext", PC_Next,  32'h20);

    // Grant withheld for three cycles at PC 0x20.
    step(); Imem_Gnt = 1'b0; #1;
    chk("drain11_pc",  Instr_PC, 32'h18);
    chk("gnt11_pcnext", PC_Next, 32'h20);
    step();
    chk("drain12_pc",  Instr_PC, 32'h1C);
    chk("gnt12_pcnext", PC_Next, 32'h20);
    chk("gnt12_req",   {31'h0, Imem_Req}, 32'h1);
    step();
    chk("gnt13_valid", {31'h0, Instr_Valid}, 32'h0);
    chk("gnt13_pcnext", PC_Next, 32'h20);
    step(); Imem_Gnt = 1'b1; #1;
    chk("gnt14_pcnext", PC_Next, 32'h24);
    chk("gnt14_valid", {31'h0, Instr_Valid}, 32'h0);
    step();
    chk("gnt15_valid", {31'h0, Instr_Valid}, 32'h0);
    step();
    chk("gnt16_valid", {31'h0, Instr_Valid}, 32'h1);
    chk("gnt16_pc",    Instr_PC, 32'h20);

    // Redirect to 0x8 with one response returning in the same cycle, then
    // build up two outstanding requests (0x8, 0xC) and redirect to 0x103.
    step(); mem_hold = 1'b1; Redirect = 1'b1; Redirect_Target = 32'h8; #1;
    chk("redir17_pcnext", PC_Next, 32'h8);
    chk("redir17_req", {31'h0, Imem_Req}, 32'h0);
    step(); Redirect = 1'b0; #1;
    chk("redir18_valid", {31'h0, Instr_Valid}, 32'h0);
    chk("redir18_pcnext", PC_Next, 32'hC);
    step();
    chk("redir19_pcnext", PC_Next, 32'h10);
    step();
    chk("redir20_req", {31'h0, Imem_Req}, 32'h0);
    Redirect = 1'b1; Redirect_Target = 32'h103; mem_hold = 1'b0; #1;
    chk("redir20_pcnext", PC_Next, 32'h100);
    step(); Redirect = 1'b0; #1;
    chk("drop21_valid", {31'h0, Instr_Valid}, 32'h0);
    chk("drop21_req",   {31'h0, Imem_Req}, 32'h0);
    chk("drop21_pcnext", PC_Next, 32'h100);
    step();
    chk("drop22_valid", {31'h0, Instr_Valid}, 32'h0);
    chk("drop22_pcnext", PC_Next, 32'h104);
    step();
    chk("drop23_valid", {31'h0, Instr_Valid}, 32'h0);
    step();
    chk("tgt24_valid", {31'h0, Instr_Valid}, 32'h1);
    chk("tgt24_pc",    Instr_PC, 32'h100);
    chk("tgt24_instr", Instr,    32'h1000_0100);

    // Redirect coinciding with the only outstanding response.
    step(); Redirect = 1'b1; Redirect_Target = 32'h200; #1;
    chk("same25_pcnext", PC_Next, 32'h200);
    chk("same25_req", {31'h0, Imem_Req}, 32'h0);
    chk("same25_pc",  Instr_PC, 32'h104);
    step(); Redirect = 1'b0; #1;
    chk("same26_valid", {31'h0, Instr_Valid}, 32'h0);
    chk("same26_req",   {31'h0, Imem_Req}, 32'h1);
    chk("same26_pcnext", PC_Next, 32'h204);
    step();
    chk("same27_valid", {31'h0, Instr_Valid}, 32'h0);
    step();
    chk("same28_valid", {31'h0, Instr_Valid}, 32'h1);
    chk("same28_pc",    Instr_PC, 32'h200);
    chk("same28_instr", Instr,    32'h1000_0200);

    // Asynchronous reset pulse between edges.
    #1; Reset_n = 1'b0; #1;
    chk("arst_valid",   {31'h0, Instr_Valid}, 32'h0);
    chk("arst_req",     {31'h0, Imem_Req},    32'h0);
    chk("arst_instrpc", Instr_PC, 32'h0);
    chk("arst_instr",   Instr,    32'h0);
    step(); Reset_n = 1'b1; #1;
    chk("rel29_req",    {31'h0, Imem_Req}, 32'h1);
    chk("rel29_pcnext", PC_Next, 32'h4);
    step();
    chk("rel30_valid", {31'h0, Instr_Valid}, 32'h0);
    step();
    chk("rel31_valid", {31'h0, Instr_Valid}, 32'h1);
    chk("rel31_pc",    Instr_PC, 32'h0);
    chk("rel31_instr", Instr,    32'h1000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
